// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - post-run state extractor: run core, freeze, stream out storage arrays
//
// Runs the core for RUN_CYCLES cycles (or until halt), then freezes it and
// scans N_SRC storage arrays word by word through a shared synchronous read
// port, streaming each word with source/index tags over a valid/ready link.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a run (IDLE/DONE only)
//   halt        in   early freeze request (RUN only)
//   cpu_stall   out  holds the core frozen
//   rd_en       out  read strobe to the selected source
//   rd_sel      out  source select
//   rd_addr     out  word index
//   rd_data     in   selected word, valid the cycle after rd_en
//   out_valid   out  stream word valid
//   out_ready   in   consumer accepts
//   out_data    out  word value
//   out_src     out  source tag
//   out_idx     out  index tag
//   out_last    out  final word of the dump
//   done        out  scan complete (level)
//   cycle_count out  cycles executed in the last run
module state_dump_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 32,
    parameter int N_SRC      = 3,
    parameter int SRC_W      = 2,
    parameter int CNT_W      = 16,
    parameter int RUN_CYCLES = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    output logic              cpu_stall,
    output logic              rd_en,
    output logic [SRC_W-1:0]  rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SRC_W-1:0]  out_src,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(RUN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [SRC_W-1:0]  LAST_SRC = SRC_W'(N_SRC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                cpu_stall_q;
    logic                rd_en_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [SRC_W-1:0]    out_src_q;
    logic [ADDR_W-1:0]   out_idx_q;
    logic                out_last_q;
    logic                done_q;
    logic [CNT_W-1:0]    cycle_count_q;

    // Next scan position; wraps the index into the following source.
    always_comb begin
        src_d = src_q;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
            idx_d = '0;
            src_d = src_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            src_q         <= '0;
            idx_q         <= '0;
            cpu_stall_q   <= 1'b1;
            rd_en_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_src_q     <= '0;
            out_idx_q     <= '0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_RUN;
                        cycle_count_q <= '0;
                        cpu_stall_q   <= 1'b0;
                        done_q        <= 1'b0;
                    end
                end
                S_RUN: begin
                    // The exit cycle is itself an executed cycle, so it is counted.
                    cycle_count_q <= cycle_count_q + 1'b1;
                    if (halt || (cycle_count_q == LAST_CYC)) begin
                        state_q     <= S_ISSUE;
                        cpu_stall_q <= 1'b1;
                        src_q       <= '0;
                        idx_q       <= '0;
                        rd_en_q     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    out_data_q  <= rd_data;
                    out_src_q   <= src_q;
                    out_idx_q   <= idx_q;
                    out_last_q  <= (src_q == LAST_SRC) && (idx_q == LAST_IDX);
                    out_valid_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            src_q   <= src_d;
                            idx_q   <= idx_d;
                            rd_en_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_stall   = cpu_stall_q;
    assign rd_en       = rd_en_q;
    assign rd_sel      = src_q;
    assign rd_addr     = idx_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign out_idx     = out_idx_q;
    assign out_last    = out_last_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// tb/tb_state_dump_unit.sv - self-checking bench for state_dump_unit
module tb_state_dump_unit;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int DP = 4;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int CW = 16;
    localparam int RC = 10;
    localparam int NW = NS * DP;

    logic          clk;
    logic          reset;
    logic          start;
    logic          halt;
    logic          cpu_stall;
    logic          rd_en;
    logic [SW-1:0] rd_sel;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_src;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          done;
    logic [CW-1:0] cycle_count;

    logic [DW-1:0] mem [0:3][0:3];

    int tests = 0;
    int fails = 0;

    state_dump_unit #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .N_SRC(NS),
        .SRC_W(SW), .CNT_W(CW), .RUN_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .cpu_stall(cpu_stall), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .out_idx(out_idx),
        .out_last(out_last), .done(done), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read port of the storage arrays.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_sel][rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preset_mem(input bit rnd);
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 4; i++)
                mem[s][i] = rnd ? $urandom : ((s << 20) | i);
    endtask

    // halt_at: RUN cycle to pulse halt in (-1 = none)
    // rmode:   0 ready high, 1 pattern 1,0,0,1, 2 random
    // inject:  start with halt in the start cycle, start during SEND, halt during ISSUE
    // abort_w: word number at which reset is pulsed (-1 = none)
    task automatic run_scan(input int halt_at, input int rmode, input bit inject, input int abort_w);
        int  len;
        int  n;
        bit  hold;
        bit  got_done;
        bit  r;
        logic [DW-1:0] pd;
        logic [SW-1:0] ps;
        logic [AW-1:0] pi;
        bit  pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        len = (halt_at >= 0) ? halt_at + 1 : RC;

        @(negedge clk);
        start = 1'b1;
        halt  = inject;
        @(negedge clk);
        start = 1'b0;
        halt  = 1'b0;
        chk("stall_low_after_start", cpu_stall, 0);
        chk("count_cleared", cycle_count, 0);
        chk("done_cleared", done, 0);

        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            chk("run_no_stall", cpu_stall, 0);
            chk("run_no_rd", rd_en, 0);
            halt = (k == halt_at);
        end

        n = 0; hold = 1'b0; got_done = 1'b0;
        pd = '0; ps = '0; pi = '0;
        out_ready = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            halt  = 1'b0;
            start = 1'b0;
            if (t == 0) begin
                chk("stall_after_run", cpu_stall, 1);
                chk("cycle_count", cycle_count, len);
            end
            if (rd_en && !cpu_stall) chk("rd_while_running", 1, 0);
            if (done) begin
                got_done = 1'b1;
                if (rmode == 0) chk("done_latency", t, 3 * NW);
                break;
            end
            if (out_valid) begin
                if (hold) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_src", out_src, ps);
                    chk("hold_idx", out_idx, pi);
                end else if (n >= NW) begin
                    chk("extra_word", n, NW - 1);
                end else begin
                    chk("word_data", out_data, mem[n / DP][n % DP]);
                    chk("word_src", out_src, n / DP);
                    chk("word_idx", out_idx, n % DP);
                    chk("word_last", out_last, n == NW - 1);
                    if (n == abort_w) begin
                        reset = 1'b0;
                        #1;
                        chk("rst_valid", out_valid, 0);
                        chk("rst_done", done, 0);
                        chk("rst_stall", cpu_stall, 1);
                        chk("rst_rd", rd_en, 0);
                        @(negedge clk);
                        reset = 1'b1;
                        return;
                    end
                end
                pd = out_data; ps = out_src; pi = out_idx;
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = pat[t % 4];
                    default: r = 1'($urandom);
                endcase
                out_ready = r;
                hold = !r;
                if (r) n++;
                if (inject) start = 1'b1;
            end else begin
                hold = 1'b0;
                out_ready = (rmode == 0) ? 1'b1 : 1'($urandom);
            end
            if (inject && rd_en) halt = 1'b1;
        end
        chk("done_reached", got_done, 1);
        chk("word_total", n, NW);
        chk("final_count", cycle_count, len);
        chk("done_stall", cpu_stall, 1);
        chk("done_no_valid", out_valid, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; halt = 1'b0; out_ready = 1'b1;
        preset_mem(1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("reset_stall", cpu_stall, 1);
        chk("reset_done", done, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_rd", rd_en, 0);
        chk("reset_count", cycle_count, 0);
        chk("reset_last", out_last, 0);

        run_scan(-1, 0, 1'b0, -1);
        run_scan(3, 0, 1'b0, -1);
        run_scan(-1, 1, 1'b0, -1);
        run_scan(-1, 0, 1'b1, -1);
        run_scan(-1, 0, 1'b0, 6);
        run_scan(-1, 0, 1'b0, -1);
        run_scan(0, 0, 1'b0, -1);
        run_scan(RC - 1, 0, 1'b0, -1);
        for (int it = 0; it < 4; it++) begin
            preset_mem(1'b1);
            run_scan(($urandom % 2) ? int'($urandom_range(0, RC - 1)) : -1, 2, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/state_dump_unit.md
# state_dump_unit

- Synthesizable post-run state extractor for the RISC-V core.
- Runs the processor for a programmed number of cycles or until a halt request, then freezes it.
- Reads out N_SRC storage arrays (instruction memory, data memory, register bank, ...) word by word through a shared synchronous read port.
- Streams each word with source/index tags over a valid/ready interface to a UART or capture block. Sits beside the datapath at top level.

## Interface
Parameters:
- DATA_W, 32, width of every stored word
- ADDR_W, 5, index width; every source is scanned from 0 to DEPTH-1
- DEPTH, 32, words scanned per source (DEPTH ≤ 2^ADDR_W)
- N_SRC, 3, number of sources; 0 = instruction mem, 1 = data mem, 2 = register bank
- SRC_W, 2, width of source select (2^SRC_W ≥ N_SRC)
- CNT_W, 16, run-cycle counter width
- RUN_CYCLES, 100, cycle budget before automatic freeze (1 ≤ RUN_CYCLES < 2^CNT_W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle pulse; begins a run, honoured only in IDLE or DONE
- halt  in  1  early freeze request, honoured only in RUN
- cpu_stall  out  1  holds the processor (PC and all writes) frozen
- rd_en  out  1  read strobe to the selected source
- rd_sel  out  SRC_W  source select, muxed externally
- rd_addr  out  ADDR_W  word index
- rd_data  in  DATA_W  selected word, valid the cycle after rd_en
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  word value
- out_src  out  SRC_W  source tag
- out_idx  out  ADDR_W  index tag
- out_last  out  1  high with final word (src N_SRC-1, idx DEPTH-1)
- done  out  1  scan complete, level
- cycle_count  out  CNT_W  cycles executed in the last run

## Operation
- States: IDLE, RUN, ISSUE, WAIT, SEND, DONE.
- Reset values: state IDLE, all outputs 0 except cpu_stall = 1 (the core is held out of reset-release until start).
- IDLE/DONE + start → RUN:
  - cycle_count cleared to 0, cpu_stall = 0, done = 0.
- RUN:
  - cycle_count increments every cycle.
  - On halt, or on cycle_count == RUN_CYCLES-1 → ISSUE, with src = 0 and idx = 0. cpu_stall = 1 from that cycle's next edge.
  - cycle_count then freezes; the final value includes the exit cycle.
- ISSUE: rd_en = 1 for one cycle, with rd_sel = src and rd_addr = idx. → WAIT.
- WAIT: capture rd_data into out_data. Latch out_src, out_idx and out_last. → SEND.
- SEND:
  - out_valid = 1; out_data and the tags are held stable until out_ready.
  - On out_valid & out_ready:
    - if out_last → DONE;
    - else if idx == DEPTH-1 → idx = 0, src + 1, ISSUE;
    - else idx + 1, ISSUE.
- DONE: done = 1, cpu_stall = 1, out_valid = 0. Stays until start.
- Ignored inputs:
  - start outside IDLE/DONE.
  - halt outside RUN.
  - start and halt in the same cycle while in IDLE: start wins, halt ignored.
- Reset mid-scan: immediate return to IDLE. No partial word is emitted after reset deasserts.
- Indices are unsigned; src/idx never exceed N_SRC-1/DEPTH-1.

## Timing
- start → cpu_stall low on the next edge.
- Run length is exactly RUN_CYCLES unstalled cycles when halt is not used.
- With halt asserted in RUN cycle k (0-based), cycle_count = k+1.
- Per word: 3 cycles minimum (ISSUE, WAIT, SEND with out_ready = 1). Each cycle of out_ready = 0 adds one cycle.
- Full scan with out_ready tied high: 3·N_SRC·DEPTH cycles from leaving RUN to entering DONE.
- Read port used only in ISSUE; rd_en is never high while cpu_stall = 0.

## Test plan
- DEPTH = 4, N_SRC = 3, RUN_CYCLES = 10, out_ready = 1, src s word i preset to 0xS0_000i.
  - Expect cycle_count = 10.
  - Expect 12 words in order (0,0)…(2,3), each data matching its preset.
  - Expect out_last only on (2,3).
  - Expect done 36 cycles after leaving RUN.
- halt pulsed in RUN cycle 3 → cycle_count = 4, cpu_stall high the next edge, scan proceeds normally.
- out_ready toggled 1,0,0,1 pattern → every word delivered exactly once, out_data/tags stable while stalled, no skipped indices.
- start pulsed during SEND and halt pulsed during ISSUE → no effect; sequence identical to the first scenario.
- reset low in the middle of word (1,2) → IDLE, out_valid = 0, done = 0, cpu_stall = 1. A fresh start reruns from cycle 0 with first word (0,0).
- start in DONE → done drops, new run of RUN_CYCLES, second full dump identical to the first.
